// File: rtl/add_sub_chunked.sv
// add_sub_chunked
//   Multi-cycle adder/subtractor for the CPU datapath. A WIDTH-bit operation
//   is processed CHUNK bits per clock, LSB chunk first. A registered carry
//   links the chunks, so an operation takes N = WIDTH/CHUNK cycles in RUN.
//   The FSM runs IDLE -> RUN -> DONE, with a one-cycle done pulse.
//   The result and the carry/zero/overflow flags are held until the next
//   operation completes. The enable input gates the visible outputs only.
//
//   Optional feature macro: ADD_SAT_EN
//     When defined, this adds input port sat, which is latched with start.
//     sat selects unsigned saturation of the result.

module add_sub_chunked #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic             cIn,
   input  logic [WIDTH-1:0] dIn0,
   input  logic [WIDTH-1:0] dIn1,
`ifdef ADD_SAT_EN
   input  logic             sat,
`endif
   input  logic             enable,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] dOut,
   output logic             cOut,
   output logic             zero,
   output logic             ovf
);

   localparam int N     = WIDTH / CHUNK;
   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   if ((WIDTH % CHUNK) != 0 || CHUNK < 1) begin : g_bad_params
      $error("add_sub_chunked: WIDTH must be a positive multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_next;

   // Latched operation: operand A, operand B after optional inversion,
   // running chunk carry, chunk index and partially assembled sum.
   logic [WIDTH-1:0]  r_a;
   logic [WIDTH-1:0]  r_b;
   logic              r_carry;
   logic [IDX_W-1:0]  r_idx;
   logic [WIDTH-1:0]  r_sum;
`ifdef ADD_SAT_EN
   logic              r_sub;
   logic              r_sat;
`endif

   // Held result and flags, as seen by the accumulator.
   logic [WIDTH-1:0]  r_dout;
   logic              r_cout;
   logic              r_zero;
   logic              r_ovf;

   logic              w_accept;
   logic              w_last;
   logic [CHUNK-1:0]  w_a_chunk;
   logic [CHUNK-1:0]  w_b_chunk;
   logic [CHUNK:0]    w_chunk_full;
   logic [WIDTH-1:0]  w_sum_next;
   logic              w_carry_out;
   logic              w_ovf;
   logic [WIDTH-1:0]  w_result;

   // A start request is honoured only when no operation is in flight.
   // This also gives back-to-back operations out of DONE.
   assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
   assign w_last   = (r_state == S_RUN) && (r_idx == LAST_IDX);

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: every register in a clocked block is written with <=.
      // Then all flops see pre-edge values, whatever the statement order.
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      // NOTE: a default is assigned before the case statement.
      // This way no path leaves w_state_next unassigned, so no latch is inferred.
      w_state_next = r_state;
      unique case (r_state)
         S_IDLE:  if (start) w_state_next = S_RUN;
         S_RUN:   if (r_idx == LAST_IDX) w_state_next = S_DONE;
         S_DONE:  w_state_next = start ? S_RUN : S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   // One chunk of the addition, plus the result as it will look after this chunk.
   always_comb begin
      w_a_chunk    = r_a[int'(r_idx)*CHUNK +: CHUNK];
      w_b_chunk    = r_b[int'(r_idx)*CHUNK +: CHUNK];
      w_chunk_full = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK+1)'(r_carry);
      w_sum_next   = r_sum;
      w_sum_next[int'(r_idx)*CHUNK +: CHUNK] = w_chunk_full[CHUNK-1:0];
      w_carry_out  = w_chunk_full[CHUNK];
   end

   // Final flags and optional saturation; only meaningful on the last chunk.
   always_comb begin
      // B is already post-inversion, so this is the plain same-sign rule.
      w_ovf    = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum_next[WIDTH-1] != r_a[WIDTH-1]);
      w_result = w_sum_next;
`ifdef ADD_SAT_EN
      if (r_sat) begin
         if (!r_sub && w_carry_out) begin
            w_result = '1;
         end else if (r_sub && !w_carry_out) begin
            w_result = '0;
         end
      end
`endif
   end

   // Operand latch and chunk sequencing.
   always_ff @(posedge clk) begin
      // NOTE: these working registers are deliberately not reset.
      // Every accepted start reloads them before they are read.
      // Also, reset forces the FSM to IDLE, so stale contents are never used.
      if (w_accept) begin
         r_a     <= dIn0;
         r_b     <= sub ? ~dIn1 : dIn1;
         r_carry <= sub ? ~cIn : cIn;
         r_idx   <= '0;
`ifdef ADD_SAT_EN
         r_sub   <= sub;
         r_sat   <= sat;
`endif
      end else if (r_state == S_RUN) begin
         r_sum   <= w_sum_next;
         r_carry <= w_carry_out;
         if (!w_last) begin
            r_idx <= r_idx + IDX_W'(1);
         end
      end
   end

   // Result and flag registers.
   // They are cleared by reset, and updated only on the RUN -> DONE edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dout <= '0;
         r_cout <= 1'b0;
         r_zero <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_last) begin
         r_dout <= w_result;
         r_cout <= w_carry_out;
         r_zero <= (w_result == '0);
         r_ovf  <= w_ovf;
      end
   end

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign dOut = enable ? r_dout : '0;
   assign cOut = enable & r_cout;
   assign zero = enable & r_zero;
   assign ovf  = enable & r_ovf;

endmodule

// File: tb/tb_add_sub_chunked.sv
// Directed testbench for add_sub_chunked with WIDTH=8 and CHUNK=4 (two cycles in RUN).
// Each scenario task drives its own stimulus and checks inline against hand-computed values.

module tb_add_sub_chunked;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       sub = 1'b0;
   logic       cIn = 1'b0;
   logic [7:0] dIn0 = 8'h00;
   logic [7:0] dIn1 = 8'h00;
`ifdef ADD_SAT_EN
   logic       sat = 1'b0;
`endif
   logic       enable = 1'b1;
   logic       busy;
   logic       done;
   logic [7:0] dOut;
   logic       cOut;
   logic       zero;
   logic       ovf;

   int n_checks = 0;
   int n_errors = 0;

   add_sub_chunked #(.WIDTH(8), .CHUNK(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .sub    (sub),
      .cIn    (cIn),
      .dIn0   (dIn0),
      .dIn1   (dIn1),
`ifdef ADD_SAT_EN
      .sat    (sat),
`endif
      .enable (enable),
      .busy   (busy),
      .done   (done),
      .dOut   (dOut),
      .cOut   (cOut),
      .zero   (zero),
      .ovf    (ovf)
   );

   always #5 clk = ~clk;

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation. lat is the cycle index where done was seen (bounded at 10).
   task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                         input logic ci, output int lat);
      dIn0  = a;
      dIn1  = b;
      sub   = s;
      cIn   = ci;
      start = 1'b1;
      step();
      start = 1'b0;
      lat   = 1;
      while (done !== 1'b1 && lat < 10) begin
         step();
         lat++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", done); end
      n_checks++; if (dOut !== 8'h00) begin n_errors++; $display("FAIL reset_dout got %h exp 00", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b000) begin n_errors++; $display("FAIL reset_flags got %b exp 000", {cOut, zero, ovf}); end
      rst = 1'b0;
      step();
   endtask

   task automatic test_add();
      int lat;
      // 0x3C + 0x0F, busy in cycle 1 then done in cycle 3.
      dIn0 = 8'h3C; dIn1 = 8'h0F; sub = 1'b0; cIn = 1'b0; start = 1'b1;
      step();
      start = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL add1_busy_c1 got %b exp 1", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL add1_done_c1 got %b exp 0", done); end
      step();
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL add1_done_c2 got %b exp 0", done); end
      step();
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL add1_done_c3 got %b exp 1", done); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL add1_busy_c3 got %b exp 0", busy); end
      n_checks++; if (dOut !== 8'h4B) begin n_errors++; $display("FAIL add1_dout got %h exp 4B", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b000) begin n_errors++; $display("FAIL add1_flags got %b exp 000", {cOut, zero, ovf}); end
      step();
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL add1_done_pulse got %b exp 0", done); end
      n_checks++; if (dOut !== 8'h4B) begin n_errors++; $display("FAIL add1_hold got %h exp 4B", dOut); end

      // 0xFF + 0x01 wraps to zero with a carry out.
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
      n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL add2_lat got %0d exp 3", lat); end
      n_checks++; if (dOut !== 8'h00) begin n_errors++; $display("FAIL add2_dout got %h exp 00", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b110) begin n_errors++; $display("FAIL add2_flags got %b exp 110", {cOut, zero, ovf}); end
      step();

      // 0x0F + 0x01: the carry crosses the chunk boundary.
      run_op(8'h0F, 8'h01, 1'b0, 1'b0, lat);
      n_checks++; if (dOut !== 8'h10) begin n_errors++; $display("FAIL add3_dout got %h exp 10", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b000) begin n_errors++; $display("FAIL add3_flags got %b exp 000", {cOut, zero, ovf}); end
      step();

      // 0x7F + 0x00 + cIn = 0x80: signed overflow, no carry.
      run_op(8'h7F, 8'h00, 1'b0, 1'b1, lat);
      n_checks++; if (dOut !== 8'h80) begin n_errors++; $display("FAIL add4_dout got %h exp 80", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b001) begin n_errors++; $display("FAIL add4_flags got %b exp 001", {cOut, zero, ovf}); end
      step();
   endtask

   task automatic test_sub();
      int lat;
      // 0x50 - 0x70 = 0xE0 with a borrow (cOut=0).
      run_op(8'h50, 8'h70, 1'b1, 1'b0, lat);
      n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL sub1_lat got %0d exp 3", lat); end
      n_checks++; if (dOut !== 8'hE0) begin n_errors++; $display("FAIL sub1_dout got %h exp E0", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b000) begin n_errors++; $display("FAIL sub1_flags got %b exp 000", {cOut, zero, ovf}); end
      step();
      // 0x80 - 0x01 = 0x7F: no borrow, signed overflow.
      run_op(8'h80, 8'h01, 1'b1, 1'b0, lat);
      n_checks++; if (dOut !== 8'h7F) begin n_errors++; $display("FAIL sub2_dout got %h exp 7F", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b101) begin n_errors++; $display("FAIL sub2_flags got %b exp 101", {cOut, zero, ovf}); end
      step();
      // 0x05 - 0x05 = 0: zero is set, with no borrow.
      run_op(8'h05, 8'h05, 1'b1, 1'b0, lat);
      n_checks++; if (dOut !== 8'h00) begin n_errors++; $display("FAIL sub3_dout got %h exp 00", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b110) begin n_errors++; $display("FAIL sub3_flags got %b exp 110", {cOut, zero, ovf}); end
      step();
      // 0x10 - 0x01 - borrow-in 1 = 0x0E.
      run_op(8'h10, 8'h01, 1'b1, 1'b1, lat);
      n_checks++; if (dOut !== 8'h0E) begin n_errors++; $display("FAIL sub4_dout got %h exp 0E", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b100) begin n_errors++; $display("FAIL sub4_flags got %b exp 100", {cOut, zero, ovf}); end
      step();
   endtask

   task automatic test_start_in_run();
      int n_done = 0;
      int done_cyc = 0;
      logic [7:0] res = 8'h00;
      dIn0 = 8'h11; dIn1 = 8'h22; sub = 1'b0; cIn = 1'b0; start = 1'b1;
      step();                       // cycle 1: RUN
      dIn0 = 8'hAA; dIn1 = 8'h55; sub = 1'b1; start = 1'b1;
      step();                       // cycle 2: start was sampled in RUN
      start = 1'b0;
      for (int c = 2; c < 10; c++) begin
         if (done === 1'b1) begin
            n_done++;
            done_cyc = c;
            res = dOut;
         end
         step();
      end
      n_checks++; if (n_done !== 1) begin n_errors++; $display("FAIL run_start_dones got %0d exp 1", n_done); end
      n_checks++; if (done_cyc !== 3) begin n_errors++; $display("FAIL run_start_cycle got %0d exp 3", done_cyc); end
      n_checks++; if (res !== 8'h33) begin n_errors++; $display("FAIL run_start_dout got %h exp 33", res); end
   endtask

   task automatic test_back_to_back();
      dIn0 = 8'h01; dIn1 = 8'h02; sub = 1'b0; cIn = 1'b0; start = 1'b1;
      step();
      step();
      step();                       // cycle 3: DONE
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL b2b_done1 got %b exp 1", done); end
      n_checks++; if (dOut !== 8'h03) begin n_errors++; $display("FAIL b2b_dout1 got %h exp 03", dOut); end
      dIn0 = 8'h10; dIn1 = 8'h20;   // start still high, so it is accepted in DONE
      step();                       // cycle 4
      start = 1'b0;
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy got %b exp 1", busy); end
      n_checks++; if (dOut !== 8'h03) begin n_errors++; $display("FAIL b2b_hold got %h exp 03", dOut); end
      step();
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL b2b_early got %b exp 0", done); end
      step();                       // cycle 6
      n_checks++; if (done !== 1'b1) begin n_errors++; $display("FAIL b2b_done2 got %b exp 1", done); end
      n_checks++; if (dOut !== 8'h30) begin n_errors++; $display("FAIL b2b_dout2 got %h exp 30", dOut); end
      step();
   endtask

   task automatic test_reset_mid();
      int n_done = 0;
      dIn0 = 8'h3C; dIn1 = 8'h0F; sub = 1'b0; cIn = 1'b0; start = 1'b1;
      step();                       // cycle 1
      start = 1'b0;
      step();                       // cycle 2
      rst = 1'b1;
      step();                       // cycle 3: reset took effect
      rst = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL rstmid_done got %b exp 0", done); end
      n_checks++; if (dOut !== 8'h00) begin n_errors++; $display("FAIL rstmid_dout got %h exp 00", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b000) begin n_errors++; $display("FAIL rstmid_flags got %b exp 000", {cOut, zero, ovf}); end
      for (int c = 0; c < 6; c++) begin
         step();
         if (done === 1'b1) n_done++;
      end
      n_checks++; if (n_done !== 0) begin n_errors++; $display("FAIL rstmid_no_done got %0d exp 0", n_done); end
   endtask

   task automatic test_enable();
      int lat;
      enable = 1'b0;
      run_op(8'h80, 8'h01, 1'b1, 1'b0, lat);
      n_checks++; if (lat !== 3) begin n_errors++; $display("FAIL en_lat got %0d exp 3", lat); end
      n_checks++; if (dOut !== 8'h00) begin n_errors++; $display("FAIL en_gated_dout got %h exp 00", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b000) begin n_errors++; $display("FAIL en_gated_flags got %b exp 000", {cOut, zero, ovf}); end
      step();
      enable = 1'b1;
      #1;
      n_checks++; if (dOut !== 8'h7F) begin n_errors++; $display("FAIL en_show_dout got %h exp 7F", dOut); end
      n_checks++; if ({cOut, zero, ovf} !== 3'b101) begin n_errors++; $display("FAIL en_show_flags got %b exp 101", {cOut, zero, ovf}); end
      enable = 1'b0;
      run_op(8'hFF, 8'h01, 1'b0, 1'b0, lat);
      n_checks++; if ({cOut, zero, ovf} !== 3'b000) begin n_errors++; $display("FAIL en_gated_zero got %b exp 000", {cOut, zero, ovf}); end
      enable = 1'b1;
      #1;
      n_checks++; if ({cOut, zero, ovf} !== 3'b110) begin n_errors++; $display("FAIL en_show_zero got %b exp 110", {cOut, zero, ovf}); end
      step();
   endtask

`ifdef ADD_SAT_EN
   task automatic test_sat();
      int lat;
      sat = 1'b1;
      run_op(8'hF0, 8'h20, 1'b0, 1'b0, lat);
      n_checks++; if (dOut !== 8'hFF) begin n_errors++; $display("FAIL sat_add_dout got %h exp FF", dOut); end
      n_checks++; if ({cOut, zero} !== 2'b10) begin n_errors++; $display("FAIL sat_add_flags got %b exp 10", {cOut, zero}); end
      step();
      run_op(8'h10, 8'h20, 1'b1, 1'b0, lat);
      n_checks++; if (dOut !== 8'h00) begin n_errors++; $display("FAIL sat_sub_dout got %h exp 00", dOut); end
      n_checks++; if ({cOut, zero} !== 2'b01) begin n_errors++; $display("FAIL sat_sub_flags got %b exp 01", {cOut, zero}); end
      step();
      run_op(8'h10, 8'h20, 1'b0, 1'b0, lat);
      n_checks++; if (dOut !== 8'h30) begin n_errors++; $display("FAIL sat_plain_dout got %h exp 30", dOut); end
      step();
      sat = 1'b0;
   endtask
`endif

   initial begin
      #1;
      test_reset();
      test_add();
      test_sub();
      test_start_in_run();
      test_back_to_back();
      test_reset_mid();
      test_enable();
`ifdef ADD_SAT_EN
      test_sat();
`endif
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
